vga_text_fetch: RTL and testbench

VGA_TEXT_FETCH -- requirements
Module: vga_text_fetch

---
 rtl/vga_text_fetch.sv | 154 +++++++++++++++
 tb/tb_vga_text_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_fetch.sv
// Four-stage text-mode fetch pipeline: pixel position -> text buffer -> font ROM -> renderer.
// Also overlays a blinking underline cursor and keeps positions aligned with the pixel data.
module vga_text_fetch #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned CURSOR_TOP = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_pos,
    input  logic [9:0]  v_pos,
    output logic [11:0] tb_addr,
    input  logic [7:0]  tb_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [9:0]  h_pos_out,
    output logic [9:0]  v_pos_out,
    output logic [7:0]  character,
    output logic [3:0]  row,
    output logic [7:0]  pixels,
    output logic        active_out
);

    localparam int unsigned PW       = 10;
    localparam int unsigned AW       = 12;
    localparam int unsigned DW       = 8;
    localparam int unsigned FW       = 5;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned ROWS     = V_ACTIVE / 16;

    // Stage 1 combinational decode of the incoming position
    logic [6:0]    ccol_c;
    logic [4:0]    crow_c;
    logic [AW-1:0] row_base_c;
    logic          active_c;
    logic          hit_c;

    assign ccol_c   = h_pos[9:3];
    assign crow_c   = v_pos[8:4];
    assign active_c = (h_pos < PW'(H_ACTIVE)) && (v_pos < PW'(V_ACTIVE));

    generate
        if (COLS == 80) begin : g_stride80
            assign row_base_c = {1'b0, crow_c, 6'b0} + {3'b0, crow_c, 4'b0};
        end else begin : g_stride_gen
            assign row_base_c = AW'(crow_c) * AW'(COLS);
        end
    endgenerate

    // Out-of-range cursor coordinates are rejected explicitly so they can never match
    assign hit_c = cursor_en && active_c
                && (cursor_col < 7'(COLS)) && (cursor_row < 5'(ROWS))
                && (ccol_c == cursor_col) && (crow_c == cursor_row)
                && (v_pos[3:0] >= 4'(CURSOR_TOP));

    // Pipeline state
    logic [AW-1:0] tb_addr_q, tb_addr_d;
    logic [PW-1:0] h1_q, h2_q, h3_q, v1_q, v2_q, v3_q;
    logic          act1_q, act2_q, act3_q;
    logic          hit1_q, hit2_q, hit3_q;
    logic          blink1_q, blink2_q, blink3_q;
    logic [DW-1:0] char3_q;
    logic [FW-1:0] frame_q, frame_d;

    logic [PW-1:0] hout_q, vout_q;
    logic [DW-1:0] char_q, pix_q, pix_d;
    logic [3:0]    row_q;
    logic          act_q;

    always_comb begin
        tb_addr_d = '0;
        frame_d   = frame_q;
        pix_d     = font_data;
        if (active_c) begin
            tb_addr_d = row_base_c + AW'(ccol_c);
        end
        if ((h_pos == '0) && (v_pos == '0)) begin
            frame_d = frame_q + FW'(1);
        end
        if (!act3_q) begin
            pix_d = '0;
        end else if (hit3_q && blink3_q) begin
            pix_d = 8'hFF;
        end
    end

    // Blink phase is sampled when the pixel enters, so a pixel's cursor state is fixed at stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_addr_q <= '0;
            h1_q      <= '0;
            v1_q      <= '0;
            act1_q    <= 1'b0;
            hit1_q    <= 1'b0;
            blink1_q  <= 1'b0;
            h2_q      <= '0;
            v2_q      <= '0;
            act2_q    <= 1'b0;
            hit2_q    <= 1'b0;
            blink2_q  <= 1'b0;
            h3_q      <= '0;
            v3_q      <= '0;
            act3_q    <= 1'b0;
            hit3_q    <= 1'b0;
            blink3_q  <= 1'b0;
            char3_q   <= '0;
            hout_q    <= '0;
            vout_q    <= '0;
            char_q    <= '0;
            row_q     <= '0;
            pix_q     <= '0;
            act_q     <= 1'b0;
            frame_q   <= '0;
        end else begin
            tb_addr_q <= tb_addr_d;
            h1_q      <= h_pos;
            v1_q      <= v_pos;
            act1_q    <= active_c;
            hit1_q    <= hit_c;
            blink1_q  <= frame_q[FW-1];
            h2_q      <= h1_q;
            v2_q      <= v1_q;
            act2_q    <= act1_q;
            hit2_q    <= hit1_q;
            blink2_q  <= blink1_q;
            h3_q      <= h2_q;
            v3_q      <= v2_q;
            act3_q    <= act2_q;
            hit3_q    <= hit2_q;
            blink3_q  <= blink2_q;
            char3_q   <= tb_data;
            hout_q    <= h3_q;
            vout_q    <= v3_q;
            char_q    <= char3_q;
            row_q     <= v3_q[3:0];
            pix_q     <= pix_d;
            act_q     <= act3_q;
            frame_q   <= frame_d;
        end
    end

    assign tb_addr    = tb_addr_q;
    assign font_addr  = {tb_data, v2_q[3:0]};
    assign h_pos_out  = hout_q;
    assign v_pos_out  = vout_q;
    assign character  = char_q;
    assign row        = row_q;
    assign pixels     = pix_q;
    assign active_out = act_q;

endmodule

// File: tb/tb_vga_text_fetch.sv
// Bench for vga_text_fetch: directed pipeline/cursor/reset vectors plus a multi-line sweep
// against a behavioural text/font model with synchronous memory models.
module tb_vga_text_fetch;

    localparam logic [9:0] IDLE_H = 10'd700;
    localparam logic [9:0] IDLE_V = 10'd500;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_pos, v_pos;
    logic [11:0] tb_addr, font_addr;
    logic [7:0]  tb_data, font_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [9:0]  h_pos_out, v_pos_out;
    logic [7:0]  character, pixels;
    logic [3:0]  row;
    logic        active_out;

    logic [7:0]  text_mem [4096];
    logic [7:0]  font_mem [4096];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [4:0]  fc;
    logic [11:0] addr_s1, faddr_s2;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] chr;
        logic [3:0] row;
        logic [9:0] h;
        logic [9:0] v;
        logic       act;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vga_text_fetch #(.COLS(80), .CURSOR_TOP(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .tb_addr    (tb_addr),
        .tb_data    (tb_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .h_pos_out  (h_pos_out),
        .v_pos_out  (v_pos_out),
        .character  (character),
        .row        (row),
        .pixels     (pixels),
        .active_out (active_out)
    );

    // Synchronous text RAM and font ROM, one cycle read latency
    always @(posedge clk) begin
        tb_data   <= text_mem[tb_addr];
        font_data <= font_mem[font_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel in, three idle cycles, then sample the renderer outputs for that pixel
    task automatic probe(input logic [9:0] h, input logic [9:0] v);
        h_pos = h;
        v_pos = v;
        @(posedge clk); #1;
        addr_s1 = tb_addr;
        h_pos = IDLE_H;
        v_pos = IDLE_V;
        @(posedge clk); #1;
        faddr_s2 = font_addr;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        h_pos = 10'd0;
        v_pos = 10'd0;
        repeat (n) @(posedge clk);
        #1;
        h_pos = IDLE_H;
        v_pos = IDLE_V;
    endtask

    // Streamed pixel with model prediction, checked four cycles after entry
    task automatic step(input logic [9:0] h, input logic [9:0] v);
        exp_t        e;
        logic        act, hit, blink;
        logic [11:0] a;
        h_pos = h;
        v_pos = v;
        act   = (h < 10'd640) && (v < 10'd480);
        a     = act ? 12'(int'(v[8:4]) * 80 + int'(h[9:3])) : 12'd0;
        e.chr = text_mem[a];
        hit   = cursor_en && act && (h[9:3] == cursor_col) && (v[8:4] == cursor_row)
             && (v[3:0] >= 4'd14);
        blink = fc[4];
        if (h == 10'd0 && v == 10'd0) fc = fc + 5'd1;
        e.pix = !act ? 8'h00 : (hit && blink) ? 8'hFF : font_mem[{e.chr, v[3:0]}];
        e.row = v[3:0];
        e.h   = h;
        e.v   = v;
        e.act = act;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            chk($sformatf("pix h=%0d v=%0d", e.h, e.v), 32'(pixels), 32'(e.pix));
            chk($sformatf("chr h=%0d v=%0d", e.h, e.v), 32'(character), 32'(e.chr));
            chk($sformatf("row h=%0d v=%0d", e.h, e.v), 32'(row), 32'(e.row));
            chk($sformatf("hout h=%0d v=%0d", e.h, e.v), 32'(h_pos_out), 32'(e.h));
            chk($sformatf("act h=%0d v=%0d", e.h, e.v), 32'(active_out), 32'(e.act));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lines[11] = '{0, 1, 44, 45, 46, 47, 48, 478, 479, 480, 481};

        for (int i = 0; i < 4096; i++) begin
            text_mem[i] = 8'($urandom);
            font_mem[i] = 8'($urandom);
        end
        text_mem[0]   = 8'hDB;
        for (int r = 0; r < 16; r++) font_mem[{8'hDB, 4'(r)}] = 8'hFF;
        text_mem[81]  = 8'h41;
        font_mem[12'h410] = 8'h7E;
        text_mem[165] = 8'h20;
        font_mem[12'h20D] = 8'h3C;
        font_mem[12'h20E] = 8'h18;
        font_mem[12'h20F] = 8'h18;
        text_mem[166] = 8'h41;
        font_mem[12'h41E] = 8'h5A;

        rst        = 1'b1;
        h_pos      = IDLE_H;
        v_pos      = IDLE_V;
        cursor_en  = 1'b0;
        cursor_col = 7'd5;
        cursor_row = 5'd2;
        @(posedge clk); #1;
        chk("rst tb_addr", 32'(tb_addr), 32'd0);
        chk("rst pixels", 32'(pixels), 32'd0);
        chk("rst character", 32'(character), 32'd0);
        chk("rst h_pos_out", 32'(h_pos_out), 32'd0);
        chk("rst active_out", 32'(active_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        probe(10'd8, 10'd16);
        chk("cell tb_addr", 32'(addr_s1), 32'd81);
        chk("cell font_addr", 32'(faddr_s2), 32'h410);
        chk("cell character", 32'(character), 32'h41);
        chk("cell row", 32'(row), 32'd0);
        chk("cell h_pos_out", 32'(h_pos_out), 32'd8);
        chk("cell v_pos_out", 32'(v_pos_out), 32'd16);
        chk("cell active_out", 32'(active_out), 32'd1);
        chk("cell pixels", 32'(pixels), 32'h7E);

        probe(10'd639, 10'd479);
        chk("last tb_addr", 32'(addr_s1), 32'd2399);
        chk("last active_out", 32'(active_out), 32'd1);
        probe(10'd640, 10'd479);
        chk("hblank tb_addr", 32'(addr_s1), 32'd0);
        chk("hblank active_out", 32'(active_out), 32'd0);
        chk("hblank pixels", 32'(pixels), 32'd0);
        probe(10'd10, 10'd480);
        chk("vblank tb_addr", 32'(addr_s1), 32'd0);
        chk("vblank pixels", 32'(pixels), 32'd0);

        cursor_en = 1'b1;
        frames(16);
        probe(10'd40, 10'd46);
        chk("cur h40 r14", 32'(pixels), 32'hFF);
        probe(10'd47, 10'd46);
        chk("cur h47 r14", 32'(pixels), 32'hFF);
        probe(10'd47, 10'd47);
        chk("cur h47 r15", 32'(pixels), 32'hFF);
        probe(10'd48, 10'd46);
        chk("cur h48 miss", 32'(pixels), 32'h5A);
        probe(10'd40, 10'd45);
        chk("cur r13 miss", 32'(pixels), 32'h3C);
        cursor_en = 1'b0;
        probe(10'd40, 10'd46);
        chk("cur disabled", 32'(pixels), 32'h18);
        cursor_en  = 1'b1;
        cursor_col = 7'd85;
        probe(10'd680, 10'd46);
        chk("cur col85 pixels", 32'(pixels), 32'd0);
        chk("cur col85 active", 32'(active_out), 32'd0);
        cursor_col = 7'd5;

        v_pos = 10'd46;
        for (int i = 0; i < 8; i++) begin
            h_pos = 10'(40 + i);
            @(posedge clk); #1;
            if (i >= 3) chk($sformatf("stream h=%0d", 37 + i), 32'(pixels), 32'hFF);
        end
        chk("stream h_pos_out", 32'(h_pos_out), 32'd44);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst tb_addr", 32'(tb_addr), 32'd0);
        chk("midrst h_pos_out", 32'(h_pos_out), 32'd0);
        chk("midrst v_pos_out", 32'(v_pos_out), 32'd0);
        chk("midrst character", 32'(character), 32'd0);
        chk("midrst row", 32'(row), 32'd0);
        chk("midrst pixels", 32'(pixels), 32'd0);
        chk("midrst active_out", 32'(active_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        probe(10'd40, 10'd46);
        chk("postrst pixels", 32'(pixels), 32'h18);
        chk("postrst character", 32'(character), 32'h20);
        chk("postrst h_pos_out", 32'(h_pos_out), 32'd40);
        chk("postrst row", 32'(row), 32'd14);

        frames(15);
        probe(10'd40, 10'd46);
        chk("frame15 pixels", 32'(pixels), 32'h18);
        frames(1);
        probe(10'd40, 10'd46);
        chk("frame16 pixels", 32'(pixels), 32'hFF);

        fc = 5'd16;
        exp_q.delete();
        foreach (lines[k]) begin
            for (int h = 0; h < 800; h++) step(10'(h), 10'(lines[k]));
        end
        repeat (3) step(IDLE_H, IDLE_V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
